spw_light_tick_capture: RTL and testbench
=========================================

SPW_LIGHT_TICK_CAPTURE -- requirements
Module: spw_light_tick_capture

Interface
REQ-001 SHALL have parameter: DEPTH, 4, time-code FIFO entries (power of two, 2..16).
REQ-002 SHALL have ports:
- clk  input  1  sole clock.
- reset_n  input  1  asynchronous active-low reset.
- address  input  2  Avalon-MM word address.
- chipselect  input  1  slave select.
- read_n  input  1  active-low read strobe.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- readdata  output  32  read data, zero-wait.
- irq  output  1  level interrupt.
- tick_in  input  1  one-cycle pulse from SpaceWire core, time code received.
- time_in  input  8  received code: [7:6] control flags, [5:0] time value; valid when tick_in=1.

Function
REQ-003 SHALL decode rd = chipselect & ~read_n and wr = chipselect & ~write_n.
REQ-004 SHALL drive readdata combinationally from address in the same cycle, with unused bits reading 0.
REQ-005 SHALL map addr 0 DATA (read): [7:0] FIFO head, [8] valid (FIFO non-empty); 0 when empty.
REQ-006 SHALL pop the FIFO on rd & address==0 & non-empty; pop takes effect at the next clk edge.
REQ-007 SHALL leave FIFO unchanged for rd on addr 0 while empty.
REQ-008 SHALL map addr 1 STATUS: [4:0] count, [8] overflow sticky, [9] seq_err sticky; write 1 to bit 8/9 clears it.
REQ-009 SHALL map addr 2 IRQ_MASK (R/W): [0] non-empty, [1] overflow, [2] seq_err enables; other bits read 0.
REQ-010 SHALL map addr 3 LAST (read-only): [7:0] last received code, [31:16] 16-bit tick counter wrapping 0xFFFF->0.
REQ-011 SHALL push time_in on tick_in when count<DEPTH, with latency 1 (visible in DATA next cycle).
REQ-012 SHALL, on tick_in with count==DEPTH and no pop that cycle, drop the code and set overflow.
REQ-013 SHALL, on tick_in and pop in the same cycle, accept both with count unchanged and overflow unset, including when full.
REQ-014 SHALL update LAST and increment the tick counter on every tick_in, dropped codes included.
REQ-015 SHALL let set win over clear when a sticky-bit set and a write-1-clear coincide.
REQ-016 SHALL drive irq = |(IRQ_MASK & {seq_err, overflow, non-empty}), registered (1-cycle latency).
REQ-017 SHALL ignore writes to addr 0 and addr 3.

Reset
REQ-018 SHALL on reset_n=0 asynchronously clear: FIFO pointers, count=0, overflow, seq_err, IRQ_MASK, LAST, tick counter, first-seen flag, irq=0; readdata then reads 0 at addr 0.
REQ-019 SHALL leave FIFO storage contents uninitialised (unobservable while count=0).
REQ-020 SHALL, on reset mid-operation, discard all queued codes with no pop or irq glitch after release.

Configuration
REQ-021 SHALL, with SPW_TICK_SEQ_CHECK_EN defined, set seq_err on tick_in when first-seen=1 and time_in[5:0] != (LAST[5:0]+1) mod 64 (63->0 legal); set first-seen on the first tick.
REQ-022 SHALL, without SPW_TICK_SEQ_CHECK_EN, tie STATUS[9] and IRQ_MASK[2] to 0 and compile out seq_err logic.

Structure
REQ-023 SHALL define register addresses, STATUS/IRQ_MASK bit positions and the DEPTH default in package spw_tick_pkg.
REQ-024 SHALL implement storage as sub-module spw_tick_fifo (sync FIFO, show-ahead head, push/pop/count/full/empty).

Verification
REQ-025 SHALL cover: tick_in with time_in=0x05 -> next cycle DATA=0x105, STATUS count=1; read addr 0 -> count=0, DATA=0.
REQ-026 SHALL cover: 5 ticks (0x01..0x05), DEPTH=4, no reads -> count=4, overflow=1, pops return 0x01..0x04, LAST=0x05, counter=5.
REQ-027 SHALL cover: FIFO full, tick 0x2A with simultaneous pop -> overflow stays 0, count=4, last pop yields 0x2A.
REQ-028 SHALL cover: IRQ_MASK=0x1, one tick -> irq=1 two cycles after tick; drain -> irq=0 one cycle after pop; write STATUS 0x100 -> overflow cleared.
REQ-029 SHALL cover, with SPW_TICK_SEQ_CHECK_EN: codes 0x3F then 0x00 -> seq_err=0; then 0x02 -> seq_err=1; without the macro STATUS[9]=0.
REQ-030 SHALL cover: reset_n asserted with count=3 -> count=0, irq=0, LAST=0 immediately, no pop on release.

Source files
------------

// File: rtl/spw_tick_pkg.sv
// spw_tick_pkg
//   Shared constants for the SpaceWire time-code capture block: register
//   word addresses, STATUS / IRQ_MASK bit positions, the default FIFO depth
//   and a small helper for the expected next time value.
//   Optional build macro used by the block: SPW_TICK_SEQ_CHECK_EN.
package spw_tick_pkg;

  localparam int DEPTH_DEFAULT = 4;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_STATUS   = 2'd1;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_LAST     = 2'd3;

  localparam int DATA_VALID_BIT = 8;

  localparam int STAT_OVF_BIT = 8;
  localparam int STAT_SEQ_BIT = 9;

  localparam int MASK_NE_BIT  = 0;
  localparam int MASK_OVF_BIT = 1;
  localparam int MASK_SEQ_BIT = 2;

  // Time values count modulo 64, so 63 -> 0 is a legal successor.
  function automatic logic [5:0] next_time(input logic [5:0] t);
    return t + 6'd1;
  endfunction

endpackage

// File: rtl/spw_light_tick_capture_if.sv
// spw_light_tick_capture_if
//   Avalon-MM slave bus of the time-code capture block.
//   address[1:0], chipselect, read_n, write_n, writedata[31:0] : master -> slave
//   readdata[31:0]                                          : slave -> master (zero-wait)
interface spw_light_tick_capture_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read_n, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read_n, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/spw_tick_fifo.sv
// spw_tick_fifo
//   Synchronous show-ahead FIFO: dout_o always presents the head entry.
//   clk, reset_n       : clock, async active-low reset (pointers/count only)
//   push_i, din_i      : write request and data
//   pop_i              : read request (head advances at the next edge)
//   dout_o             : head entry, meaningful only while !empty_o
//   count_o, full_o, empty_o : occupancy
//   A push while full is accepted only when a pop happens in the same cycle.
module spw_tick_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // DEPTH is a power of two, so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; stale entries are never visible while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/spw_light_tick_capture.sv
// spw_light_tick_capture
//   Captures SpaceWire time codes into a small FIFO readable over Avalon-MM.
//   clk, reset_n : sole clock, async active-low reset
//   bus          : Avalon-MM slave (address/chipselect/read_n/write_n/writedata/readdata)
//   tick_in      : one-cycle pulse, time code received
//   time_in      : received code, [7:6] flags, [5:0] time value
//   irq          : registered level interrupt
//   Registers: 0 DATA, 1 STATUS, 2 IRQ_MASK, 3 LAST.
//   Build macro SPW_TICK_SEQ_CHECK_EN enables time-value sequence checking.
module spw_light_tick_capture
  import spw_tick_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset_n,
  spw_light_tick_capture_if.slave       bus,
  input  logic                          tick_in,
  input  logic [7:0]                    time_in,
  output logic                          irq
);

  localparam int CW = $clog2(DEPTH) + 1;

`ifdef SPW_TICK_SEQ_CHECK_EN
  localparam logic [2:0] MASK_IMPL = 3'b111;
`else
  localparam logic [2:0] MASK_IMPL = 3'b011;
`endif

  logic          rd, wr, pop;
  logic          full, empty;
  logic [CW-1:0] count;
  logic [7:0]    head;

  logic          ovf_q, ovf_d;
  logic [2:0]    mask_q, mask_d;
  logic [7:0]    last_q, last_d;
  logic [15:0]   tick_cnt_q, tick_cnt_d;
  logic          irq_q, irq_d;
  logic          seq_err;
  logic          wr_status_clr_ovf;
  logic          unused_wdata;

  assign rd  = bus.chipselect & ~bus.read_n;
  assign wr  = bus.chipselect & ~bus.write_n;
  assign pop = rd & (bus.address == ADDR_DATA) & ~empty;

  assign wr_status_clr_ovf = wr & (bus.address == ADDR_STATUS) & bus.writedata[STAT_OVF_BIT];
  assign unused_wdata      = ^bus.writedata;

  // The FIFO itself accepts a push while full only if it is also popping,
  // so tick_in can be passed straight through.
  spw_tick_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (tick_in),
    .pop_i   (pop),
    .din_i   (time_in),
    .dout_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

`ifdef SPW_TICK_SEQ_CHECK_EN
  logic seq_err_q, seq_err_d;
  logic first_seen_q, first_seen_d;

  always_comb begin
    seq_err_d    = seq_err_q;
    first_seen_d = first_seen_q;
    if (wr && (bus.address == ADDR_STATUS) && bus.writedata[STAT_SEQ_BIT]) seq_err_d = 1'b0;
    if (tick_in) begin
      first_seen_d = 1'b1;
      if (first_seen_q && (time_in[5:0] != next_time(last_q[5:0]))) seq_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seq_err_q    <= 1'b0;
      first_seen_q <= 1'b0;
    end else begin
      seq_err_q    <= seq_err_d;
      first_seen_q <= first_seen_d;
    end
  end

  assign seq_err = seq_err_q;
`else
  assign seq_err = 1'b0;
`endif

  always_comb begin
    ovf_d      = ovf_q;
    mask_d     = mask_q;
    last_d     = last_q;
    tick_cnt_d = tick_cnt_q;
    // Clear first so a coincident overflow set takes priority.
    if (wr_status_clr_ovf) ovf_d = 1'b0;
    if (tick_in && full && !pop) ovf_d = 1'b1;
    if (wr && (bus.address == ADDR_IRQ_MASK)) mask_d = bus.writedata[2:0] & MASK_IMPL;
    if (tick_in) begin
      last_d     = time_in;
      tick_cnt_d = tick_cnt_q + 16'd1;
    end
    irq_d = |(mask_q & {seq_err, ovf_q, ~empty});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q      <= 1'b0;
      mask_q     <= 3'b000;
      last_q     <= 8'h00;
      tick_cnt_q <= 16'h0000;
      irq_q      <= 1'b0;
    end else begin
      ovf_q      <= ovf_d;
      mask_q     <= mask_d;
      last_q     <= last_d;
      tick_cnt_q <= tick_cnt_d;
      irq_q      <= irq_d;
    end
  end

  assign irq = irq_q;

  always_comb begin
    bus.readdata = 32'h0;
    case (bus.address)
      ADDR_DATA: begin
        if (!empty) begin
          bus.readdata[7:0]            = head;
          bus.readdata[DATA_VALID_BIT] = 1'b1;
        end
      end
      ADDR_STATUS: begin
        bus.readdata[CW-1:0]       = count;
        bus.readdata[STAT_OVF_BIT] = ovf_q;
        bus.readdata[STAT_SEQ_BIT] = seq_err;
      end
      ADDR_IRQ_MASK: begin
        bus.readdata[MASK_NE_BIT]  = mask_q[MASK_NE_BIT];
        bus.readdata[MASK_OVF_BIT] = mask_q[MASK_OVF_BIT];
        bus.readdata[MASK_SEQ_BIT] = mask_q[MASK_SEQ_BIT];
      end
      ADDR_LAST: bus.readdata = {tick_cnt_q, 8'h00, last_q};
      default:   bus.readdata = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_spw_light_tick_capture.sv
module tb_spw_light_tick_capture;
  import spw_tick_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick_in = 1'b0;
  logic [7:0] time_in = 8'h00;
  logic       irq;

  spw_light_tick_capture_if bus ();

  spw_light_tick_capture #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .tick_in (tick_in),
    .time_in (time_in),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Scoreboard / reference model
  logic [7:0]  exp_q[$];
  logic        m_ovf;
  logic        m_seq;
  logic        m_first;
  logic [7:0]  m_last;
  logic [15:0] m_cnt;

  typedef struct {
    string       name;
    logic [1:0]  addr;
    logic [31:0] exp;
  } reg_vec_t;

  reg_vec_t reset_vecs[4];
  logic [7:0] fill_codes[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {22'b0, m_seq, m_ovf, 3'b000, 5'(exp_q.size())};
  endfunction

  function automatic logic [31:0] m_data();
    if (exp_q.size() == 0) return 32'h0;
    return {23'b0, 1'b1, exp_q[0]};
  endfunction

  function automatic logic [31:0] m_lastreg();
    return {m_cnt, 8'h00, m_last};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_ovf   = 1'b0;
    m_seq   = 1'b0;
    m_first = 1'b0;
    m_last  = 8'h00;
    m_cnt   = 16'h0;
  endtask

  task automatic model_tick(input logic [7:0] code);
    logic [5:0] nxt;
    nxt = m_last[5:0] + 6'd1;
`ifdef SPW_TICK_SEQ_CHECK_EN
    if (m_first && (code[5:0] != nxt)) m_seq = 1'b1;
`endif
    m_first = 1'b1;
    if (exp_q.size() < DEPTH) exp_q.push_back(code);
    else m_ovf = 1'b1;
    m_last = code;
    m_cnt  = m_cnt + 16'd1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.chipselect = 1'b0;
    bus.read_n     = 1'b1;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;
  endtask

  task automatic peek(input logic [1:0] addr, output logic [31:0] data);
    bus.address = addr;
    #1;
    data = bus.readdata;
  endtask

  task automatic peek_check(input string name, input logic [1:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    peek(addr, d);
    check(name, d, exp);
  endtask

  task automatic write_reg(input logic [1:0] addr, input logic [31:0] data);
    bus.address    = addr;
    bus.writedata  = data;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    step();
    bus_idle();
  endtask

  task automatic tick(input logic [7:0] code);
    tick_in = 1'b1;
    time_in = code;
    model_tick(code);
    step();
    tick_in = 1'b0;
  endtask

  task automatic pop_read(input string name);
    bus.address    = ADDR_DATA;
    bus.chipselect = 1'b1;
    bus.read_n     = 1'b0;
    #1;
    check(name, bus.readdata, m_data());
    step();
    bus_idle();
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic tick_pop(input logic [7:0] code, input string name);
    tick_in        = 1'b1;
    time_in        = code;
    bus.address    = ADDR_DATA;
    bus.chipselect = 1'b1;
    bus.read_n     = 1'b0;
    #1;
    check(name, bus.readdata, m_data());
    step();
    tick_in = 1'b0;
    bus_idle();
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    model_tick(code);
  endtask

  task automatic tick_clear_ovf(input logic [7:0] code);
    tick_in        = 1'b1;
    time_in        = code;
    bus.address    = ADDR_STATUS;
    bus.writedata  = 32'h100;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    m_ovf = 1'b0;
    model_tick(code);
    step();
    tick_in = 1'b0;
    bus_idle();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    logic [31:0] d;

    reset_vecs[0] = '{"rst_data",   ADDR_DATA,     32'h0};
    reset_vecs[1] = '{"rst_status", ADDR_STATUS,   32'h0};
    reset_vecs[2] = '{"rst_mask",   ADDR_IRQ_MASK, 32'h0};
    reset_vecs[3] = '{"rst_last",   ADDR_LAST,     32'h0};
    fill_codes    = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};

    bus.address = 2'd0;
    bus_idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    step();

    foreach (reset_vecs[i]) peek_check(reset_vecs[i].name, reset_vecs[i].addr, reset_vecs[i].exp);
    check("rst_irq", {31'b0, irq}, 32'h0);

    // single tick, latency 1
    tick(8'h05);
    peek_check("single_data", ADDR_DATA, 32'h105);
    peek_check("single_status", ADDR_STATUS, m_status());
    pop_read("single_pop");
    peek_check("single_data_empty", ADDR_DATA, 32'h0);
    peek_check("single_status_empty", ADDR_STATUS, m_status());
    pop_read("pop_while_empty");
    peek_check("empty_pop_status", ADDR_STATUS, m_status());

    // overflow: five ticks into DEPTH=4
    do_reset();
    for (int i = 0; i < 5; i++) tick(fill_codes[i]);
    peek_check("ovf_status", ADDR_STATUS, m_status());
    check("ovf_status_const", m_status() & 32'h11F, 32'h104);
    peek_check("ovf_last", ADDR_LAST, 32'h0005_0005);
    for (int i = 0; i < 4; i++) pop_read($sformatf("ovf_pop%0d", i));
    write_reg(ADDR_STATUS, 32'h100);
    m_ovf = 1'b0;
    peek_check("ovf_cleared", ADDR_STATUS, m_status());

    // full FIFO with simultaneous tick and pop
    for (int i = 0; i < 4; i++) tick(8'h10 + 8'(i));
    tick_pop(8'h2A, "full_tickpop_head");
    peek_check("full_tickpop_status", ADDR_STATUS, m_status());
    for (int i = 0; i < 4; i++) pop_read($sformatf("full_drain%0d", i));

    // irq on non-empty
    write_reg(ADDR_IRQ_MASK, 32'h1);
    peek_check("mask_rb", ADDR_IRQ_MASK, 32'h1);
    tick(8'h07);
    check("irq_lat1", {31'b0, irq}, 32'h0);
    step();
    check("irq_lat2", {31'b0, irq}, 32'h1);
    pop_read("irq_pop");
    check("irq_after_pop_edge", {31'b0, irq}, 32'h1);
    step();
    check("irq_drained", {31'b0, irq}, 32'h0);

    // irq on overflow, set wins over clear
    write_reg(ADDR_IRQ_MASK, 32'h2);
    for (int i = 0; i < 5; i++) tick(8'h21 + 8'(i));
    step();
    check("irq_ovf", {31'b0, irq}, 32'h1);
    tick_clear_ovf(8'h26);
    peek_check("set_wins_status", ADDR_STATUS, m_status());
    write_reg(ADDR_STATUS, 32'h100);
    m_ovf = 1'b0;
    peek_check("ovf_clear2", ADDR_STATUS, m_status());
    step();
    check("irq_ovf_cleared", {31'b0, irq}, 32'h0);
    for (int i = 0; i < 4; i++) pop_read($sformatf("irq_drain%0d", i));
    peek_check("last_after_drop", ADDR_LAST, m_lastreg());

    // sequence checking
    do_reset();
    write_reg(ADDR_IRQ_MASK, 32'h7);
`ifdef SPW_TICK_SEQ_CHECK_EN
    peek_check("mask_seq_rb", ADDR_IRQ_MASK, 32'h7);
`else
    peek_check("mask_seq_rb", ADDR_IRQ_MASK, 32'h3);
`endif
    write_reg(ADDR_IRQ_MASK, 32'h0);
    tick(8'h3F);
    tick(8'h00);
    peek(ADDR_STATUS, d);
    check("seq_wrap_ok", {31'b0, d[9]}, 32'h0);
    tick(8'h02);
    peek(ADDR_STATUS, d);
`ifdef SPW_TICK_SEQ_CHECK_EN
    check("seq_err_set", {31'b0, d[9]}, 32'h1);
`else
    check("seq_err_set", {31'b0, d[9]}, 32'h0);
`endif
    peek_check("seq_status_model", ADDR_STATUS, m_status());
    for (int i = 0; i < 3; i++) pop_read($sformatf("seq_drain%0d", i));

    // reset mid-operation
    do_reset();
    write_reg(ADDR_IRQ_MASK, 32'h1);
    for (int i = 0; i < 3; i++) tick(8'h31 + 8'(i));
    step();
    peek_check("prerst_status", ADDR_STATUS, 32'h3);
    check("prerst_irq", {31'b0, irq}, 32'h1);
    reset_n = 1'b0;
    model_reset();
    #1;
    peek_check("inrst_status", ADDR_STATUS, 32'h0);
    check("inrst_irq", {31'b0, irq}, 32'h0);
    peek_check("inrst_last", ADDR_LAST, 32'h0);
    peek_check("inrst_data", ADDR_DATA, 32'h0);
    step();
    reset_n = 1'b1;
    repeat (3) step();
    peek_check("postrst_status", ADDR_STATUS, 32'h0);
    peek_check("postrst_data", ADDR_DATA, 32'h0);
    check("postrst_irq", {31'b0, irq}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
